div_unit: RTL and testbench

Sequential 32-bit unsigned integer divider computing quotient and remainder of `y / x` with a one-bit-per-cycle restoring algorithm. It is the shared arithmetic engine of the PRNG datapath (Schrage steps: `m / a`, `seed / q`, final `mod m`). It is started by a one-cycle enable pulse and reports completion with a one-cycle done pulse.

---
 rtl/div_pkg.sv | 21 ++
 rtl/div_step.sv | 29 ++
 rtl/div_unit.sv | 138 +++++++++++++
 tb/tb_div_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// ============================================================================
// Module : div_pkg
// Desc   : Shared types and constants for the sequential restoring divider.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package div_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module : div_step
// Desc   : One combinational restoring-division step (shift, compare, subtract).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic             i_msb,
   input  logic [WIDTH-1:0] i_dvs,
   output logic [WIDTH-1:0] o_rem,
   output logic             o_qbit
);

   logic [WIDTH:0] w_trial;

   // Extra top bit keeps the carry out of the shift for the compare.
   assign w_trial = {i_rem, i_msb};
   assign o_qbit  = (w_trial >= {1'b0, i_dvs});
   assign o_rem   = o_qbit ? (w_trial[WIDTH-1:0] - i_dvs) : w_trial[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
// Module : div_unit
// Desc   : Sequential one-bit-per-cycle restoring divider, q = y / x, r = y % x.
//          Define DIV_SIGNED_EN for two's-complement operands.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module div_unit
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] y,
   input  logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             done
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [WIDTH-1:0] dvd_q,   dvd_d;
   logic [WIDTH-1:0] dvs_q,   dvs_d;
   logic [WIDTH-1:0] rem_q,   rem_d;
   logic [WIDTH-1:0] quo_q,   quo_d;
   logic [WIDTH-1:0] res_q,   res_d;
   logic             done_q,  done_d;
`ifdef DIV_SIGNED_EN
   logic             qneg_q,  qneg_d;
   logic             rneg_q,  rneg_d;
`endif

   logic [WIDTH-1:0] w_step_rem;
   logic             w_step_qbit;

   div_step #(.WIDTH(WIDTH)) u_step (
      .i_rem  (rem_q),
      .i_msb  (dvd_q[WIDTH-1]),
      .i_dvs  (dvs_q),
      .o_rem  (w_step_rem),
      .o_qbit (w_step_qbit)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      res_d   = res_q;
      done_d  = 1'b0;
`ifdef DIV_SIGNED_EN
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
`endif
      // A start pulse in any state restarts; an aborted run never reaches DONE.
      if (en) begin
`ifdef DIV_SIGNED_EN
         dvd_d  = y[WIDTH-1] ? -y : y;
         dvs_d  = x[WIDTH-1] ? -x : x;
         qneg_d = (y[WIDTH-1] ^ x[WIDTH-1]) && (x != '0);
         rneg_d = y[WIDTH-1];
`else
         dvd_d  = y;
         dvs_d  = x;
`endif
         rem_d   = '0;
         cnt_d   = CNT_W'(WIDTH);
         state_d = ST_RUN;
      end else begin
         case (state_q)
            ST_RUN: begin
               rem_d = w_step_rem;
               dvd_d = {dvd_q[WIDTH-2:0], w_step_qbit};
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
            end
            ST_DONE: begin
`ifdef DIV_SIGNED_EN
               // Divide-by-zero keeps the all-ones quotient, i.e. -1.
               quo_d = qneg_q ? -dvd_q : dvd_q;
               res_d = rneg_q ? -rem_q : rem_q;
`else
               quo_d = dvd_q;
               res_d = rem_q;
`endif
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         res_q   <= '0;
         done_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         res_q   <= res_d;
         done_q  <= done_d;
`ifdef DIV_SIGNED_EN
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
`endif
      end
   end

   assign q    = quo_q;
   assign r    = res_q;
   assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// Module : tb_div_unit
// Desc   : Directed self-checking bench for div_unit (honours DIV_SIGNED_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en  = 1'b0;
   logic [31:0] y   = '0;
   logic [31:0] x   = '0;
   logic [31:0] q;
   logic [31:0] r;
   logic        done;

   int pass_cnt  = 0;
   int total_cnt = 0;

   div_unit #(.WIDTH(32)) dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .y    (y),
      .x    (x),
      .q    (q),
      .r    (r),
      .done (done)
   );

   always #5 clk = ~clk;

   // Pulses en for one cycle, then watches 40 cycles; lat is the cycle index
   // (relative to the en edge) of the first done, or -1 if none.
   task automatic run_op(input logic [31:0] yy, input logic [31:0] xx,
                         output int lat, output int ndone,
                         output logic [31:0] qq, output logic [31:0] rr);
      lat = -1; ndone = 0; qq = '0; rr = '0;
      @(negedge clk); en = 1'b1; y = yy; x = xx;
      @(negedge clk); en = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            ndone++;
            if (lat < 0) begin lat = n; qq = q; rr = r; end
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      total_cnt++;
      if ({done, q, r} !== 65'd0) $display("FAIL reset_state: done=%b q=%h r=%h, want 0/0/0", done, q, r);
      else pass_cnt++;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int lat, nd; logic [31:0] qq, rr;
      run_op(32'd2147483647, 32'd16807, lat, nd, qq, rr);
      total_cnt++;
      if (lat !== 33 || nd !== 1) $display("FAIL basic_timing: lat=%0d ndone=%0d, want 33/1", lat, nd);
      else pass_cnt++;
      total_cnt++;
      if (qq !== 32'd127773 || rr !== 32'd2836) $display("FAIL basic_result: q=%0d r=%0d, want 127773/2836", qq, rr);
      else pass_cnt++;
      total_cnt++;
      if (q !== 32'd127773 || r !== 32'd2836) $display("FAIL basic_hold: q=%0d r=%0d, want 127773/2836", q, r);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int lat, nd;
      logic [31:0] q1 = 32'hDEAD_BEEF, r1 = 32'hDEAD_BEEF;
      logic        seen = 1'b0;
      @(negedge clk); en = 1'b1; y = 32'd5; x = 32'd127773;
      @(negedge clk); en = 1'b0;
      for (int n = 1; n <= 40 && !seen; n++) begin
         @(negedge clk);
         if (done === 1'b1) begin seen = 1'b1; q1 = q; r1 = r; end
      end
      total_cnt++;
      if (!seen || q1 !== 32'd0 || r1 !== 32'd5) $display("FAIL small_dividend: seen=%b q=%0d r=%0d, want 1/0/5", seen, q1, r1);
      else pass_cnt++;
      // New start issued during the done cycle.
      en = 1'b1; y = 32'd100; x = 32'd7;
      @(negedge clk); en = 1'b0;
      lat = -1; nd = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            nd++;
            if (lat < 0) begin lat = n; q1 = q; r1 = r; end
         end
      end
      total_cnt++;
      if (lat !== 33 || nd !== 1) $display("FAIL b2b_timing: lat=%0d ndone=%0d, want 33/1", lat, nd);
      else pass_cnt++;
      total_cnt++;
      if (q1 !== 32'd14 || r1 !== 32'd2) $display("FAIL b2b_result: q=%0d r=%0d, want 14/2", q1, r1);
      else pass_cnt++;
   endtask

   task automatic test_div_zero();
      int lat, nd; logic [31:0] qq, rr;
      run_op(32'd100, 32'd0, lat, nd, qq, rr);
      total_cnt++;
      if (lat !== 33 || qq !== 32'hFFFF_FFFF || rr !== 32'd100) $display("FAIL div_zero: lat=%0d q=%h r=%0d, want 33/ffffffff/100", lat, qq, rr);
      else pass_cnt++;
      run_op(32'hFFFF_FFFF, 32'd1, lat, nd, qq, rr);
      total_cnt++;
      if (lat !== 33 || qq !== 32'hFFFF_FFFF || rr !== 32'd0) $display("FAIL div_one: lat=%0d q=%h r=%h, want 33/ffffffff/0", lat, qq, rr);
      else pass_cnt++;
   endtask

   task automatic test_abort();
      int lat = -1, nd = 0;
      logic [31:0] qq = '0, rr = '0;
      @(negedge clk); en = 1'b1; y = 32'd1000; x = 32'd3;
      @(negedge clk); en = 1'b0;
      for (int n = 1; n <= 9; n++) begin
         @(negedge clk);
         if (done === 1'b1) nd++;
         if (n == 5) begin
            total_cnt++;
            if (q !== 32'hFFFF_FFFF || r !== 32'd0) $display("FAIL hold_midop: q=%h r=%h, want ffffffff/0", q, r);
            else pass_cnt++;
         end
      end
      en = 1'b1; y = 32'd81; x = 32'd9;
      @(negedge clk); en = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            nd++;
            if (lat < 0) begin lat = n; qq = q; rr = r; end
         end
      end
      total_cnt++;
      if (lat !== 33 || nd !== 1) $display("FAIL abort_timing: lat=%0d ndone=%0d, want 33/1", lat, nd);
      else pass_cnt++;
      total_cnt++;
      if (qq !== 32'd9 || rr !== 32'd0) $display("FAIL abort_result: q=%0d r=%0d, want 9/0", qq, rr);
      else pass_cnt++;
   endtask

   task automatic test_reset_midop();
      int lat, nd = 0; logic [31:0] qq, rr;
      @(negedge clk); en = 1'b1; y = 32'd1000; x = 32'd3;
      @(negedge clk); en = 1'b0;
      repeat (14) @(negedge clk);
      rst = 1'b1;
      #1;
      total_cnt++;
      if (q !== 32'd0 || r !== 32'd0 || done !== 1'b0) $display("FAIL async_reset: q=%0d r=%0d done=%b, want 0/0/0", q, r, done);
      else pass_cnt++;
      @(negedge clk); rst = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (done === 1'b1) nd++;
      end
      total_cnt++;
      if (nd !== 0) $display("FAIL reset_no_done: ndone=%0d, want 0", nd);
      else pass_cnt++;
      run_op(32'd50, 32'd7, lat, nd, qq, rr);
      total_cnt++;
      if (lat !== 33 || qq !== 32'd7 || rr !== 32'd1) $display("FAIL after_reset: lat=%0d q=%0d r=%0d, want 33/7/1", lat, qq, rr);
      else pass_cnt++;
   endtask

`ifdef DIV_SIGNED_EN
   task automatic test_signed();
      int lat, nd; logic [31:0] qq, rr;
      run_op(32'hFFFF_FFF9, 32'd2, lat, nd, qq, rr);
      total_cnt++;
      if (qq !== 32'hFFFF_FFFD || rr !== 32'hFFFF_FFFF) $display("FAIL signed_neg_y: q=%h r=%h, want fffffffd/ffffffff", qq, rr);
      else pass_cnt++;
      run_op(32'd7, 32'hFFFF_FFFE, lat, nd, qq, rr);
      total_cnt++;
      if (qq !== 32'hFFFF_FFFD || rr !== 32'd1) $display("FAIL signed_neg_x: q=%h r=%h, want fffffffd/1", qq, rr);
      else pass_cnt++;
      run_op(32'h8000_0000, 32'hFFFF_FFFF, lat, nd, qq, rr);
      total_cnt++;
      if (lat !== 33 || qq !== 32'h8000_0000 || rr !== 32'd0) $display("FAIL signed_min: lat=%0d q=%h r=%h, want 33/80000000/0", lat, qq, rr);
      else pass_cnt++;
      run_op(32'hFFFF_FF9C, 32'd0, lat, nd, qq, rr);
      total_cnt++;
      if (qq !== 32'hFFFF_FFFF || rr !== 32'hFFFF_FF9C) $display("FAIL signed_div_zero: q=%h r=%h, want ffffffff/ffffff9c", qq, rr);
      else pass_cnt++;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_div_zero();
      test_abort();
      test_reset_midop();
`ifdef DIV_SIGNED_EN
      test_signed();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

`default_nettype wire
